// File: rtl/alu_seq.sv
// Multi-cycle execute unit: valid/ready request in, valid/ready result out, iterative shifter.
// Define ALU_SEQ_BARREL_SHIFT_EN to compute SRL/SRA in a single cycle instead.

package alu_seq_pkg;

   typedef enum logic [3:0] {
      ALU_FUNC_ADD     = 4'h0,
      ALU_FUNC_SUB     = 4'h1,
      ALU_FUNC_SLT     = 4'h2,
      ALU_FUNC_SLTU    = 4'h3,
      ALU_FUNC_XOR     = 4'h4,
      ALU_FUNC_AND     = 4'h5,
      ALU_FUNC_SRL     = 4'h6,
      ALU_FUNC_SRA     = 4'h7,
      ALU_FUNC_SEQ     = 4'h8,
      ALU_FUNC_UNKNOWN = 4'hF
   } alu_func_t;

endpackage

module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  alu_func_t       func,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            error
);

   localparam int unsigned ShW = $clog2(XLEN);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            error_q, error_d;

   logic            accept;
   logic [ShW-1:0]  shamt;
   logic [XLEN-1:0] op_result;
   logic            op_error;
   logic            go_shift;

   assign shamt = b[ShW-1:0];

   // Single-cycle datapath used at accept time.
   always_comb begin
      op_result = '0;
      op_error  = 1'b0;
      case (func)
         ALU_FUNC_ADD:  op_result = a + b;
         ALU_FUNC_SUB:  op_result = a - b;
         ALU_FUNC_SLT:  op_result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_FUNC_SLTU: op_result = {{(XLEN-1){1'b0}}, (a < b)};
         ALU_FUNC_XOR:  op_result = a ^ b;
         ALU_FUNC_AND:  op_result = a & b;
`ifdef ALU_SEQ_BARREL_SHIFT_EN
         ALU_FUNC_SRL:  op_result = a >> shamt;
         ALU_FUNC_SRA:  op_result = $unsigned($signed(a) >>> shamt);
`else
         // Only reached with shamt == 0; non-zero amounts go through StShift.
         ALU_FUNC_SRL:  op_result = a;
         ALU_FUNC_SRA:  op_result = a;
`endif
         ALU_FUNC_SEQ:  op_result = {{(XLEN-1){1'b0}}, (a == b)};
         default:       op_error  = 1'b1;
      endcase
   end

`ifndef ALU_SEQ_BARREL_SHIFT_EN
   logic [XLEN-1:0] shift_q, shift_d;
   logic [ShW-1:0]  cnt_q, cnt_d;
   logic            arith_q, arith_d;
   logic [XLEN-1:0] shift_step;

   assign go_shift   = ((func == ALU_FUNC_SRL) || (func == ALU_FUNC_SRA)) && (shamt != '0);
   assign shift_step = {arith_q & shift_q[XLEN-1], shift_q[XLEN-1:1]};
`else
   assign go_shift   = 1'b0;
`endif

   assign in_ready  = !reset && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == StDone);
   assign result    = result_q;
   assign error     = error_q;

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      error_d  = error_q;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      arith_d  = arith_q;
`endif
      unique case (state_q)
         StIdle: ;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
         StShift: begin
            shift_d = shift_step;
            cnt_d   = cnt_q - ShW'(1);
            if (cnt_q == ShW'(1)) begin
               state_d  = StDone;
               result_d = shift_step;
               error_d  = 1'b0;
            end
         end
`endif
         StDone: begin
            if (out_ready && !in_valid) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // accept is only possible from StIdle or from StDone with out_ready.
      if (accept) begin
         if (go_shift) begin
            state_d = StShift;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
            shift_d = a;
            cnt_d   = shamt;
            arith_d = (func == ALU_FUNC_SRA);
`endif
         end else begin
            state_d  = StDone;
            result_d = op_result;
            error_d  = op_error;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         result_q <= '0;
         error_q  <= 1'b0;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
         shift_q  <= '0;
         cnt_q    <= '0;
         arith_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         error_q  <= error_d;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         arith_q  <= arith_d;
`endif
      end
   end

endmodule
